// File: rtl/prbs_pkg.sv
// Shared types and the recurrence helper for the serial PRBS checker.
package prbs_pkg;

    // Checker FSM: hunting for the sequence, or tracking it and counting errors.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Predicted next bit of the linear recurrence: XOR of every history bit
    // selected by the tap mask. hist[0] is the most recent bit. Arguments are
    // zero-extended to 32 bits so one function serves any order up to 32.
    function automatic logic pred(input logic [31:0] hist, input logic [31:0] taps);
        return ^(hist & taps);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bus between a serial bit source and the PRBS checker.
//
// Handshake: valid-only. A bit on 'in' is consumed on every rising clock edge
// where in_valid is high; the checker has no backpressure and always accepts.
// clr_cnt is a level sampled each edge, independent of in_valid. All checker
// outputs are registered and change only on a rising edge.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    import prbs_pkg::*;

    logic             in;
    logic             in_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    state_t           state;      // debug view of the checker FSM

    // Source side: drives bits and the counter clear, observes status.
    modport master (
        output in, in_valid, clr_cnt,
        input  locked, err, err_count, bit_count, state
    );

    // Checker side.
    modport slave (
        input  in, in_valid, clr_cnt,
        output locked, err, err_count, bit_count, state
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. A clear and an increment in
// the same cycle yield 1: the clear is applied first, then the increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: reset, clear-then-increment, hold at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker. Self-synchronises by loading received bits into a
// history register, then predicts each next bit from the recurrence. Locks
// after a run of matches, counts errors while locked, and drops lock when too
// many errors land inside one observation window.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int          WIDTH       = 5,
    parameter int unsigned TAPS        = 'h14,
    parameter int          LOCK_CNT    = 16,
    parameter int          WINDOW      = 32,
    parameter int          UNLOCK_ERRS = 4,
    parameter int          CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_,
    prbs_checker_if.slave bus
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int WERR_W = $clog2(UNLOCK_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(UNLOCK_ERRS);

    state_t             state, state_n;
    logic [WIDTH-1:0]   hist, hist_n;
    logic [FILL_W-1:0]  fill, fill_n;
    logic [MATCH_W-1:0] match, match_n;
    logic [WIN_W-1:0]   win, win_n;
    logic [WERR_W-1:0]  winerr, winerr_n;
    logic [WERR_W-1:0]  winerr_sum;
    logic               err_q, err_n;
    logic               inc_err, inc_bit;
    logic               p_bit;
    logic               mismatch;

    // Prediction from the current history; used both while hunting and locked.
    assign p_bit    = pred(32'(hist), 32'(TAPS));
    assign mismatch = (bus.in != p_bit);

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state  <= SEARCH;
            hist   <= '0;
            fill   <= '0;
            match  <= '0;
            win    <= '0;
            winerr <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            hist   <= hist_n;
            fill   <= fill_n;
            match  <= match_n;
            win    <= win_n;
            winerr <= winerr_n;
            err_q  <= err_n;
        end
    end

    // Next-state logic: acquisition in SEARCH, error tracking in LOCKED.
    always_comb begin
        state_n    = state;
        hist_n     = hist;
        fill_n     = fill;
        match_n    = match;
        win_n      = win;
        winerr_n   = winerr;
        err_n      = 1'b0;
        inc_err    = 1'b0;
        inc_bit    = 1'b0;
        winerr_sum = winerr + WERR_W'(mismatch);

        if (bus.in_valid) begin
            case (state)
                SEARCH: begin
                    // Received bits seed the history until it can predict.
                    hist_n = {hist[WIDTH-2:0], bus.in};
                    if (fill < FILL_FULL) begin
                        fill_n = fill + FILL_W'(1);
                    end else if (!mismatch) begin
                        if (match == MATCH_LAST) begin
                            state_n  = LOCKED;
                            match_n  = '0;
                            win_n    = '0;
                            winerr_n = '0;
                        end else begin
                            match_n = match + MATCH_W'(1);
                        end
                    end else begin
                        match_n = '0;
                    end
                end

                LOCKED: begin
                    // Shift in the prediction so a channel error cannot
                    // corrupt the history and cascade into more errors.
                    hist_n  = {hist[WIDTH-2:0], p_bit};
                    inc_bit = 1'b1;
                    if (mismatch) begin
                        err_n   = 1'b1;
                        inc_err = 1'b1;
                    end
                    if (win == WIN_LAST) begin
                        win_n    = '0;
                        winerr_n = '0;
                    end else begin
                        win_n    = win + WIN_W'(1);
                        winerr_n = winerr_sum;
                    end
                    if (winerr_sum == WERR_LIMIT) begin
                        state_n  = SEARCH;
                        fill_n   = '0;
                        match_n  = '0;
                        win_n    = '0;
                        winerr_n = '0;
                    end
                end

                default: begin
                    state_n = SEARCH;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst_  (rst_),
        .clr   (bus.clr_cnt),
        .inc   (inc_err),
        .count (bus.err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_count (
        .clk   (clk),
        .rst_  (rst_),
        .clr   (bus.clr_cnt),
        .inc   (inc_bit),
        .count (bus.bit_count)
    );

    assign bus.locked = (state == LOCKED);
    assign bus.err    = err_q;
    assign bus.state  = state;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios, expected responses queued by the
// driver and checked by an independent monitor one cycle later.
module tb_prbs_checker;
    import prbs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    // Stimulus shared by both checkers; sel routes valid/clear to one of them.
    logic s_in, s_valid, s_clr, sel;

    prbs_checker_if #(.CNT_W(16)) bus_a ();
    prbs_checker_if #(.CNT_W(4))  bus_b ();

    assign bus_a.in       = s_in;
    assign bus_a.in_valid = s_valid & ~sel;
    assign bus_a.clr_cnt  = s_clr & ~sel;
    assign bus_b.in       = s_in;
    assign bus_b.in_valid = s_valid & sel;
    assign bus_b.clr_cnt  = s_clr & sel;

    prbs_checker #(.CNT_W(16)) dut_a (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_a)
    );

    prbs_checker #(.CNT_W(4), .UNLOCK_ERRS(64)) dut_b (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_b)
    );

    // ---------------- scoreboard ----------------
    // Entry: {sel, locked, err, err_count[15:0], bit_count[15:0]}
    logic [34:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int n_cmp = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (entry %0d): got %0d expected %0d", name, n_cmp, act, exp);
        end
    endtask

    // Monitor: after each edge's outputs settle, compare every queued expectation.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (e[34]) begin
                    check("b_locked", int'(bus_b.locked), int'(e[33]));
                    check("b_state", int'(bus_b.state), e[33] ? int'(LOCKED) : int'(SEARCH));
                    check("b_err", int'(bus_b.err), int'(e[32]));
                    check("b_err_count", int'(bus_b.err_count), int'(e[31:16]));
                    check("b_bit_count", int'(bus_b.bit_count), int'(e[15:0]));
                end else begin
                    check("a_locked", int'(bus_a.locked), int'(e[33]));
                    check("a_state", int'(bus_a.state), e[33] ? int'(LOCKED) : int'(SEARCH));
                    check("a_err", int'(bus_a.err), int'(e[32]));
                    check("a_err_count", int'(bus_a.err_count), int'(e[31:16]));
                    check("a_bit_count", int'(bus_a.bit_count), int'(e[15:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [4:0] gh;

    // Reference source: b[n] = b[n-3] ^ b[n-5], seeded with all ones.
    task automatic gen_bit(output logic b);
        b  = gh[2] ^ gh[4];
        gh = {gh[3:0], b};
    endtask

    // Apply one cycle of stimulus and queue what the outputs must be after it.
    task automatic step(input logic b, input logic v, input logic c,
                        input logic e_lk, input logic e_err, input int e_ec, input int e_bc);
        s_in    = b;
        s_valid = v;
        s_clr   = c;
        @(posedge clk);
        exp_q.push_back({sel, e_lk, e_err, 16'(e_ec), 16'(e_bc)});
        #1;
    endtask

    task automatic do_reset();
        rst_    = 1'b0;
        s_valid = 1'b0;
        s_clr   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            exp_q.push_back({sel, 1'b0, 1'b0, 16'd0, 16'd0});
            #1;
        end
        rst_ = 1'b1;
        gh   = 5'h1F;
    endtask

    function automatic int locked_bits(input int k, input int lock_at);
        return (k > lock_at) ? (k - lock_at) : 0;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        logic b, fl, v;
        int k, n_err, ec, bc;
        rst_    = 1'b0;
        s_in    = 1'b0;
        s_valid = 1'b0;
        s_clr   = 1'b0;
        sel     = 1'b0;
        gh      = 5'h1F;
        #1;

        // Clean stream: lock after bit 21, then 310 clean checked bits.
        do_reset();
        for (int i = 1; i <= 331; i++) begin
            gen_bit(b);
            step(b, 1'b1, 1'b0, i >= 21, 1'b0, 0, locked_bits(i, 21));
        end

        // Reset while locked with nonzero bit_count; single flip at bit 100.
        do_reset();
        for (int i = 1; i <= 150; i++) begin
            gen_bit(b);
            fl = (i == 100);
            step(b ^ fl, 1'b1, 1'b0, i >= 21, fl, (i >= 100) ? 1 : 0, locked_bits(i, 21));
        end

        // Burst of 8 flips inside the second window: unlock on the 4th error,
        // relock 21 clean bits after the burst.
        do_reset();
        for (int i = 1; i <= 130; i++) begin
            gen_bit(b);
            fl = (i >= 61) && (i <= 68);
            if (i < 61)       ec = 0;
            else if (i <= 64) ec = i - 60;
            else              ec = 4;
            if (i <= 64)      bc = locked_bits(i, 21);
            else if (i <= 89) bc = 43;
            else              bc = 43 + (i - 89);
            step(b ^ fl, 1'b1, 1'b0, (i >= 21 && i <= 63) || (i >= 89),
                 (i >= 61) && (i <= 64), ec, bc);
        end

        // Valid gaps 1,0,1,0: lock on cycle 41 (valid bit 21); idle bits ignored.
        do_reset();
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            v = c[0];
            if (v) begin
                k++;
                gen_bit(b);
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(b, v, 1'b0, k >= 21, 1'b0, 0, locked_bits(k, 21));
        end
        // Clear alone, then clear with increments in the same cycle.
        step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        gen_bit(b);
        step(b, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1);
        gen_bit(b);
        step(~b, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1);
        gen_bit(b);
        step(b, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2);

        // Narrow counters, high unlock threshold: 20 isolated errors saturate
        // err_count at 15; clear with an error in the same cycle gives 1.
        sel = 1'b1;
        do_reset();
        n_err = 0;
        for (int i = 1; i <= 101; i++) begin
            gen_bit(b);
            if (i == 100) begin
                step(~b, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1);
            end else if (i == 101) begin
                step(b, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2);
            end else begin
                fl = (i >= 30) && (i <= 87) && (((i - 30) % 3) == 0);
                if (fl) n_err++;
                ec = (n_err > 15) ? 15 : n_err;
                bc = (locked_bits(i, 21) > 15) ? 15 : locked_bits(i, 21);
                step(b ^ fl, 1'b1, 1'b0, i >= 21, fl, ec, bc);
            end
        end
        check("errors_injected", n_err, 20);

        s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker that sits directly downstream of the lfsr generator and consumes its one-bit out stream.
- Self-synchronises to the incoming sequence by loading received bits into a history register, then predicts each next bit from the linear recurrence.
- Declares lock, counts bit errors, and drops lock on an error burst so it can re-acquire.
- Used to confirm generator/link integrity in benches and BIST paths.

Parameters:
- WIDTH, 5: recurrence order (history register length).
- TAPS, 'h14: recurrence mask. Predicted bit = XOR of hist[i] for every i where TAPS[i]=1. hist[0] is the most recent bit. 'h14 encodes b[n] = b[n-3] ^ b[n-5].
- LOCK_CNT, 16: consecutive matches required to declare lock.
- WINDOW, 32: length of the lock-loss observation window, in valid bits.
- UNLOCK_ERRS, 4: errors within one window that force loss of lock.
- CNT_W, 16: width of the err_count and bit_count counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_  in  1  synchronous, active-low reset.
- in  in  1  received serial bit.
- in_valid  in  1  in is sampled only when high.
- clr_cnt  in  1  synchronous clear of err_count and bit_count; state is unaffected.
- locked  out  1  high while in state LOCKED.
- err  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  CNT_W  saturating count of errors.
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED.

Behaviour:
- Reset (rst_ low at an edge): state=SEARCH; hist, fill, match, win and winerr counters=0; locked=0, err=0, err_count=0, bit_count=0. Reset mid-stream discards all history.
- in_valid low: nothing changes, except that clr_cnt is still honoured. err=0 on the following cycle.
- SEARCH, each valid bit:
  - hist <= {hist[WIDTH-2:0], in}.
  - While fill<WIDTH: fill++ and no comparison is made.
  - Once full: compare in with the prediction from the current hist. Match → match++; mismatch → match=0.
  - When match reaches LOCK_CNT → LOCKED. locked is high the cycle after the LOCK_CNT-th match. Clean stream: lock after WIDTH+LOCK_CNT valid bits.
  - No err pulses and no counter updates in SEARCH.
- LOCKED, each valid bit:
  - pred = ^(hist & TAPS).
  - hist <= {hist[WIDTH-2:0], pred}. The predicted bit is shifted in, not the received bit, so one channel error yields exactly one counted error.
  - bit_count++.
  - If in != pred: err=1 on the next cycle, err_count++, winerr++.
  - win++; on reaching WINDOW, win=0 and winerr=0.
  - If winerr reaches UNLOCK_ERRS → SEARCH on that edge. Also fill=0 and match=0; locked low the next cycle. The error that triggers unlock is still counted and pulsed.
- Counters saturate at all-ones and never wrap.
- clr_cnt and an increment in the same cycle: clear first, then apply the increment, so the result is 1.
- All outputs are registered. Latency from the sampled bit to err/err_count is 1 cycle.

Decomposition:
- Package prbs_pkg: state enum typedef (SEARCH, LOCKED) and the shared prediction function pred(hist, taps).
- One natural sub-module, sat_counter (parameter W; inputs clr, inc), instantiated twice for err_count and bit_count.
- Window, match and fill counters stay inline.

Test Plan:
- Reset: drive rst_ low for 2 cycles mid-lock → next cycle locked=0, err=0, err_count=0, bit_count=0. A subsequent clean stream relocks after 21 valid bits.
- Clean lock: bench model with TAPS 'h14, seed 'h1F, in_valid=1 → locked rises the cycle after valid bit 21. After 310 more bits: err_count=0, bit_count=310.
- Single flip: invert valid bit 100 while locked → exactly one err pulse, err_count=1, locked stays 1.
- Burst unlock (UNLOCK_ERRS=4, WINDOW=32): invert 8 consecutive bits → locked falls the cycle after the 4th error, err_count=4. Clean stream afterwards → relock after 21 further valid bits.
- Valid gaps: in_valid pattern 1,0,1,0 with the clean stream → lock after 21 valid bits (42 cycles). err stays 0 on idle cycles.
- Counter edges (CNT_W=4, UNLOCK_ERRS=64): 20 isolated errors → err_count saturates at 15. Asserting clr_cnt in the same cycle as an error → err_count=1.
